data_sram_like_bridge: RTL and testbench

- Bridges the MEM-stage data-memory request (load/store from the M stage) onto the SRAM-like data bus.
- Produces `stall_from_mem` for the hazard unit and consumes that unit's `longest_stall` and `flush_exceptM`. It is the producing end of the memory-stall handshake.
- Holds each load/store until the bus completes it. It keeps the result stable until the whole pipeline advances, and it drains a transaction cancelled by an exception without letting it retire.

---
 rtl/data_sram_like_bridge_pkg.sv | 15 +
 rtl/data_sram_like_bridge_if.sv | 45 ++++
 rtl/data_sram_like_bridge.sv | 98 +++++++++
 tb/tb_data_sram_like_bridge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_like_bridge_pkg.sv
// Shared definitions for the MEM-stage data bridge: FSM state encoding and access-size codes.
package data_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// Pipeline, hazard-unit and SRAM-like bus signals of the data bridge.
// master = the bridge itself, slave = pipeline + hazard unit + memory.
interface data_sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_en;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              longest_stall;
    logic              flush_exceptM;
    logic              stall_from_mem;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        input  mem_en, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_rdata,
        input  longest_stall, flush_exceptM,
        output stall_from_mem,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        output mem_en, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_rdata,
        output longest_stall, flush_exceptM,
        input  stall_from_mem,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/data_sram_like_bridge.sv
// Bridges M-stage loads/stores onto the SRAM-like data bus, stalling the pipeline until each completes.
// Latency: request issues in the same cycle as mem_en, result registered on data_ok; holds DONE while longest_stall.
module data_sram_like_bridge
    import data_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    data_sram_like_bridge_if.master bus
);

    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              complete;

    // The pipeline holds the M-stage fields steady while stalled, so they drive the bus directly.
    assign req_addr       = bus.mem_addr;
    assign req_wdata      = bus.mem_wdata;
    assign bus.data_addr  = req_addr;
    assign bus.data_wdata = req_wdata;
    assign bus.data_wr    = bus.mem_wr;
    assign bus.data_size  = bus.mem_size;
    assign bus.mem_rdata  = rdata_q;

    assign bus.stall_from_mem = (bus.mem_en & ~bus.flush_exceptM & (state_q != ST_DONE))
                              | (cancel_q & bus.mem_en);

    always_comb begin
        state_d      = state_q;
        cancel_d     = cancel_q;
        rdata_d      = rdata_q;
        complete     = 1'b0;
        bus.data_req = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_en && !bus.flush_exceptM && !cancel_q) begin
                    bus.data_req = 1'b1;
                    if (bus.data_addr_ok && bus.data_data_ok) complete = 1'b1;
                    else if (bus.data_addr_ok)                state_d  = ST_WAIT;
                    else                                      state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // An accepted-or-pending request cannot be withdrawn; a flush only marks it for discard.
                bus.data_req = 1'b1;
                if (bus.flush_exceptM) cancel_d = 1'b1;
                if (bus.data_addr_ok && bus.data_data_ok) complete = 1'b1;
                else if (bus.data_addr_ok)                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.flush_exceptM) cancel_d = 1'b1;
                if (bus.data_data_ok)  complete = 1'b1;
            end
            ST_DONE: begin
                if (bus.flush_exceptM || !bus.longest_stall) state_d = ST_IDLE;
            end
        endcase

        if (complete) begin
            if (cancel_q || bus.flush_exceptM) begin
                state_d  = ST_IDLE;
                cancel_d = 1'b0;
            end else begin
                state_d = ST_DONE;
                if (!bus.mem_wr) rdata_d = bus.data_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            rdata_q  <= rdata_d;
        end
    end

`ifndef SYNTHESIS
    // data_ok is only legal once the address has been accepted; the FSM ignores it otherwise.
    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        (bus.data_data_ok && (state_q == ST_IDLE || state_q == ST_REQ))
            |-> (bus.data_req && bus.data_addr_ok));

    a_size_legal: assert property (@(posedge clk) disable iff (!resetn)
        bus.mem_en |-> (bus.mem_size <= SIZE_WORD));
`endif

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Randomized bench for data_sram_like_bridge against a byte-lane memory model and transaction-level timing rules.
module tb_data_sram_like_bridge;
    import data_sram_like_bridge_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic other_stall = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] mem_model [logic [31:0]];

    data_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Hazard unit: global stall is our own request ORed with any other stall source.
    assign bus.longest_stall = bus.stall_from_mem | other_stall;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return mem_model.exists(w) ? mem_model[w] : ~w;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] m;
        logic [31:0] old;
        w   = {a[31:2], 2'b00};
        old = mem_read(a);
        case (sz)
            SIZE_BYTE: m = 32'h0000_00FF << {a[1:0], 3'b000};
            SIZE_HALF: m = 32'h0000_FFFF << {a[1:0], 3'b000};
            default:   m = 32'hFFFF_FFFF;
        endcase
        mem_model[w] = (old & ~m) | (d & m);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access: addr_ok in cycle alat, data_ok dlat cycles later, then costall extra DONE cycles.
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wdata, input int alat, input int dlat,
                             input int costall, input bit flush_done);
        int reqs;
        int last;
        logic [31:0] rd;
        reqs = 0;
        last = alat + dlat;
        rd   = mem_read(addr);
        bus.mem_en = 1'b1; bus.mem_wr = wr; bus.mem_size = sz;
        bus.mem_addr = addr; bus.mem_wdata = wdata;
        for (int c = 0; c <= last; c++) begin
            bus.data_addr_ok = (c == alat);
            bus.data_data_ok = (c == last);
            bus.data_rdata   = (c == last) ? rd : $urandom;
            @(negedge clk);
            checks++;
            if (bus.stall_from_mem !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy: cycle %0d got %b expected 1", c, bus.stall_from_mem);
            end
            if (bus.data_req === 1'b1) begin
                reqs++;
                checks++;
                if ({bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata} !== {wr, sz, addr, wdata}) begin
                    errors++;
                    $display("FAIL req_fields: got wr=%b sz=%0d a=%h d=%h expected wr=%b sz=%0d a=%h d=%h",
                             bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata, wr, sz, addr, wdata);
                end
            end
            next_cycle();
        end
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        checks++;
        if (reqs != alat + 1) begin
            errors++;
            $display("FAIL req_cycles: got %0d expected %0d", reqs, alat + 1);
        end
        if (wr) mem_write(addr, sz, wdata);
        else    exp_rdata = rd;
        for (int k = 0; k <= costall; k++) begin
            other_stall       = (k < costall) || flush_done;
            bus.flush_exceptM = flush_done && (k == costall);
            @(negedge clk);
            checks++;
            if ({bus.stall_from_mem, bus.data_req, bus.mem_rdata} !== {1'b0, 1'b0, exp_rdata}) begin
                errors++;
                $display("FAIL done_hold: got stall=%b req=%b rdata=%h expected stall=0 req=0 rdata=%h",
                         bus.stall_from_mem, bus.data_req, bus.mem_rdata, exp_rdata);
            end
            next_cycle();
        end
        other_stall = 1'b0;
        bus.flush_exceptM = 1'b0;
        bus.mem_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.data_req, bus.stall_from_mem, bus.mem_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got req=%b stall=%b rdata=%h expected 0 0 0",
                     bus.data_req, bus.stall_from_mem, bus.mem_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_zero_wait_load();
        mem_model[32'h1000] = 32'hDEAD_BEEF;
        do_access(1'b0, SIZE_WORD, 32'h1000, 32'h0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_slow_store();
        do_access(1'b1, SIZE_WORD, 32'h2000, 32'h5A5A_0F0F, 3, 2, 0, 1'b0);
        do_access(1'b0, SIZE_WORD, 32'h2000, 32'h0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_co_stall();
        do_access(1'b0, SIZE_WORD, 32'h1000, 32'h0, 1, 1, 5, 1'b0);
    endtask

    task automatic test_flush_wait();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_size = SIZE_WORD;
        bus.mem_addr = 32'h3000; bus.mem_wdata = 32'h0;
        bus.data_addr_ok = 1'b1;
        next_cycle();
        bus.data_addr_ok = 1'b0;
        bus.flush_exceptM = 1'b1;
        next_cycle();
        bus.flush_exceptM = 1'b0;
        bus.mem_addr = 32'h3004;
        for (int c = 0; c < 2; c++) begin
            bus.data_data_ok = (c == 1);
            bus.data_rdata   = 32'h1234_5678;
            @(negedge clk);
            checks++;
            if ({bus.stall_from_mem, bus.data_req} !== 2'b10) begin
                errors++;
                $display("FAIL cancel_stall: cycle %0d got stall=%b req=%b expected stall=1 req=0",
                         c, bus.stall_from_mem, bus.data_req);
            end
            next_cycle();
        end
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.data_req, bus.data_addr, bus.mem_rdata} !== {1'b1, 32'h3004, exp_rdata}) begin
            errors++;
            $display("FAIL cancel_drain: got req=%b a=%h rdata=%h expected req=1 a=00003004 rdata=%h",
                     bus.data_req, bus.data_addr, bus.mem_rdata, exp_rdata);
        end
        next_cycle();
        do_access(1'b0, SIZE_WORD, 32'h3004, 32'h0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_flush_req();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_size = SIZE_WORD;
        bus.mem_addr = 32'h4000; bus.mem_wdata = 32'h0;
        next_cycle();
        bus.flush_exceptM = 1'b1;
        next_cycle();
        bus.flush_exceptM = 1'b0;
        bus.mem_en = 1'b0;
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBADC_0FFE;
        @(negedge clk);
        checks++;
        if ({bus.data_req, bus.stall_from_mem} !== 2'b10) begin
            errors++;
            $display("FAIL flush_req_hold: got req=%b stall=%b expected req=1 stall=0",
                     bus.data_req, bus.stall_from_mem);
        end
        next_cycle();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL flush_req_discard: got %h expected %h", bus.mem_rdata, exp_rdata);
        end
        next_cycle();
    endtask

    task automatic test_flush_idle();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_addr = 32'h1000;
        bus.flush_exceptM = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.data_req, bus.stall_from_mem} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle: got req=%b stall=%b expected 0 0", bus.data_req, bus.stall_from_mem);
        end
        next_cycle();
        bus.flush_exceptM = 1'b0;
        bus.mem_en = 1'b0;
    endtask

    task automatic test_flush_done();
        do_access(1'b0, SIZE_WORD, 32'h1000, 32'h0, 0, 1, 2, 1'b1);
        do_access(1'b1, SIZE_HALF, 32'h1002, 32'hABCD_0000, 0, 0, 0, 1'b0);
        do_access(1'b0, SIZE_WORD, 32'h1000, 32'h0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        mem_model[32'h5000] = 32'hCAFE_F00D;
        do_access(1'b0, SIZE_WORD, 32'h5000, 32'h0, 0, 0, 0, 1'b0);
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_addr = 32'h5004;
        next_cycle();
        next_cycle();
        #2;
        bus.mem_en = 1'b0;
        resetn = 1'b0;
        #1;
        exp_rdata = 32'h0;
        checks++;
        if ({bus.data_req, bus.stall_from_mem, bus.mem_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got req=%b stall=%b rdata=%h expected 0 0 0",
                     bus.data_req, bus.stall_from_mem, bus.mem_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        next_cycle();
        do_access(1'b0, SIZE_WORD, 32'h5000, 32'h0, 1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            if (sz == SIZE_HALF)      a[0]   = 1'b0;
            else if (sz == SIZE_WORD) a[1:0] = 2'b00;
            do_access(1'($urandom_range(0, 1)), sz, a, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                checks++;
                if ({bus.data_req, bus.stall_from_mem} !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_gap: got req=%b stall=%b expected 0 0", bus.data_req, bus.stall_from_mem);
                end
                next_cycle();
            end
        end
    endtask

    initial begin
        bus.mem_en = 1'b0; bus.mem_wr = 1'b0; bus.mem_size = SIZE_WORD;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.flush_exceptM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        test_reset();
        test_zero_wait_load();
        test_slow_store();
        test_co_stall();
        test_flush_wait();
        test_flush_req();
        test_flush_idle();
        test_flush_done();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
